// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the Multiple_Gates datapath: sweeps all four input
// vectors, samples the six gate outputs after a settle delay and grades them.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [1:0]  entrada,
    input  logic        in_not_a,
    input  logic        in_or,
    input  logic        in_and,
    input  logic        in_nor,
    input  logic        in_xor,
    input  logic        in_xnor,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic        pass,
    output logic [3:0]  fail_mask,
    output logic [23:0] table_out
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SLOT_W  = 6;
    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned VEC_W   = 2;
    localparam int unsigned TABLE_W = SLOT_W * NUM_VEC;

    // Expected {NOT_A,OR,AND,NOR,XOR,XNOR} per vector, vector 0 in the low slot
    localparam logic [TABLE_W-1:0] GOLDEN      = TABLE_W'(24'h652CA5);
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0]   LAST_VEC    = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [VEC_W-1:0]     entrada_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic                 aborted_nxt;
    logic                 pass_nxt;
    logic [NUM_VEC-1:0]   fail_nxt;
    logic [TABLE_W-1:0]   table_nxt;
    logic [SLOT_W-1:0]    captured;

    assign captured = {in_not_a, in_or, in_and, in_nor, in_xor, in_xnor};

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            entrada   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            table_out <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            entrada   <= entrada_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            aborted   <= aborted_nxt;
            pass      <= pass_nxt;
            fail_mask <= fail_nxt;
            table_out <= table_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        entrada_nxt = entrada;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        pass_nxt    = pass;
        fail_nxt    = fail_mask;
        table_nxt   = table_out;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_SETTLE;
                    entrada_nxt = '0;
                    cnt_nxt     = SETTLE_LOAD;
                    fail_nxt    = '0;
                    table_nxt   = '0;
                    pass_nxt    = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    state_nxt   = S_IDLE;
                    busy_nxt    = 1'b0;
                    aborted_nxt = 1'b1;
                    entrada_nxt = '0;
                    pass_nxt    = 1'b0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                // An abort here drops the pending sample; earlier slots are kept
                if (abort) begin
                    state_nxt   = S_IDLE;
                    busy_nxt    = 1'b0;
                    aborted_nxt = 1'b1;
                    entrada_nxt = '0;
                    pass_nxt    = 1'b0;
                end else begin
                    for (int v = 0; v < int'(NUM_VEC); v++) begin
                        if (entrada == VEC_W'(v)) begin
                            table_nxt[v*SLOT_W +: SLOT_W] = captured;
                            fail_nxt[v] = (captured != GOLDEN[v*SLOT_W +: SLOT_W]);
                        end
                    end
                    if (entrada == LAST_VEC) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt   = S_SETTLE;
                        entrada_nxt = entrada + VEC_W'(1);
                        cnt_nxt     = SETTLE_LOAD;
                    end
                end
            end

            S_DONE: begin
                // fail_mask already holds the last vector's verdict here
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
                pass_nxt  = (fail_mask == '0);
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (settle 1 and 0) driving a faultable
// gate model; directed scenarios followed by randomized sweeps.
module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    = 1'b1;
    logic        start1 = 1'b0, abort1 = 1'b0;
    logic        start0 = 1'b0, abort0 = 1'b0;
    logic [1:0]  entrada1, entrada0;
    logic        busy1, done1, aborted1, pass1;
    logic        busy0, done0, aborted0, pass0;
    logic [3:0]  fm1, fm0;
    logic [23:0] tab1, tab0;
    logic [5:0]  dp1, dp0;
    logic [23:0] fault_vec = '0;
    logic        stuck_and = 1'b0;
    logic        sel0      = 1'b0;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] GOLD [4] = '{6'h25, 6'h32, 6'h12, 6'h19};

    // Ideal gates: {NOT_A, OR, AND, NOR, XOR, XNOR} with A = v[1], B = v[0]
    function automatic logic [5:0] truth(input logic [1:0] v);
        logic a, b;
        a = v[1];
        b = v[0];
        return {~a, a | b, a & b, ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    function automatic logic [5:0] datapath(input logic [1:0] v, input logic [23:0] f,
                                            input logic sa);
        logic [5:0] o;
        o = truth(v) ^ f[int'(v)*6 +: 6];
        if (sa) o[3] = 1'b0;
        return o;
    endfunction

    assign dp1 = datapath(entrada1, fault_vec, stuck_and);
    assign dp0 = datapath(entrada0, fault_vec, stuck_and);

    gate_sweep_ctrl #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .entrada(entrada1),
        .in_not_a(dp1[5]), .in_or(dp1[4]), .in_and(dp1[3]),
        .in_nor(dp1[2]), .in_xor(dp1[1]), .in_xnor(dp1[0]),
        .busy(busy1), .done(done1), .aborted(aborted1), .pass(pass1),
        .fail_mask(fm1), .table_out(tab1)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .entrada(entrada0),
        .in_not_a(dp0[5]), .in_or(dp0[4]), .in_and(dp0[3]),
        .in_nor(dp0[2]), .in_xor(dp0[1]), .in_xnor(dp0[0]),
        .busy(busy0), .done(done0), .aborted(aborted0), .pass(pass0),
        .fail_mask(fm0), .table_out(tab0)
    );

    logic [1:0]  o_ent;
    logic        o_busy, o_done, o_ab, o_pass;
    logic [3:0]  o_fm;
    logic [23:0] o_tab;
    assign o_ent  = sel0 ? entrada0 : entrada1;
    assign o_busy = sel0 ? busy0    : busy1;
    assign o_done = sel0 ? done0    : done1;
    assign o_ab   = sel0 ? aborted0 : aborted1;
    assign o_pass = sel0 ? pass0    : pass1;
    assign o_fm   = sel0 ? fm0      : fm1;
    assign o_tab  = sel0 ? tab0     : tab1;

    task automatic check(input string tag, input int k, input logic [23:0] obs,
                         input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // One sweep; abort_c/restart_c/rst_c give the cycle (start edge = 0) at
    // which that input is high, 0 meaning never.
    task automatic run_sweep(input bit use0, input int abort_c, input int restart_c,
                             input int rst_c, input bit idle_abort);
        logic [5:0]  exp_slot [4];
        logic [3:0]  full_fm;
        logic [3:0]  e_fm;
        logic [23:0] e_tab;
        logic [1:0]  e_ent;
        logic        e_busy, e_done, e_ab, e_pass, st, ab;
        int          w, t, n, last;

        sel0 = use0;
        w    = use0 ? 2 : 3;
        t    = 4 * w;
        for (int v = 0; v < 4; v++) begin
            exp_slot[v] = datapath(2'(v), fault_vec, stuck_and);
            full_fm[v]  = (exp_slot[v] != GOLD[v]);
        end
        if (rst_c > 0)                      last = rst_c + 1;
        else if (abort_c > 0 && abort_c <= t) last = abort_c + 2;
        else                                last = t + 3;

        @(negedge clk);
        if (use0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            n = 0;
            if (rst_c > 0 && k > rst_c) begin
                e_busy = 0; e_done = 0; e_ab = 0; e_ent = 0; e_pass = 0;
            end else if (abort_c > 0 && abort_c <= t && k > abort_c) begin
                e_busy = 0; e_done = 0; e_ab = (k == abort_c + 1); e_ent = 0; e_pass = 0;
                for (int v = 0; v < 4; v++) if ((v + 1) * w < abort_c) n++;
            end else begin
                e_busy = (k <= t + 1);
                e_done = (k == t + 1);
                e_ab   = 1'b0;
                e_ent  = (k <= t) ? 2'((k - 1) / w) : 2'd3;
                for (int v = 0; v < 4; v++) if ((v + 1) * w <= k - 1) n++;
                e_pass = (k >= t + 2) && (full_fm == 4'd0);
            end
            e_fm  = '0;
            e_tab = '0;
            for (int v = 0; v < 4; v++) begin
                if (v < n) begin
                    e_fm[v]          = full_fm[v];
                    e_tab[v*6 +: 6]  = exp_slot[v];
                end
            end
            check("busy",      k, 24'(o_busy), 24'(e_busy));
            check("done",      k, 24'(o_done), 24'(e_done));
            check("aborted",   k, 24'(o_ab),   24'(e_ab));
            check("entrada",   k, 24'(o_ent),  24'(e_ent));
            check("pass",      k, 24'(o_pass), 24'(e_pass));
            check("fail_mask", k, 24'(o_fm),   24'(e_fm));
            check("table_out", k, o_tab,       e_tab);

            st = (k == restart_c);
            ab = (k == abort_c) || (idle_abort && k == t + 2);
            if (use0) begin start0 = st; abort0 = ab; end
            else      begin start1 = st; abort1 = ab; end
            rst = (k == rst_c);
        end
        @(negedge clk);
        start0 = 0; abort0 = 0; start1 = 0; abort1 = 0; rst = 0;
    endtask

    initial begin
        int use0, ac, rc, rsc, mode, t;
        bit ia;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy1",  0, 24'(busy1),    24'd0);
        check("rst_done1",  0, 24'(done1),    24'd0);
        check("rst_ab1",    0, 24'(aborted1), 24'd0);
        check("rst_pass1",  0, 24'(pass1),    24'd0);
        check("rst_ent1",   0, 24'(entrada1), 24'd0);
        check("rst_fm1",    0, 24'(fm1),      24'd0);
        check("rst_tab1",   0, tab1,          24'd0);
        check("rst_busy0",  0, 24'(busy0),    24'd0);
        check("rst_ent0",   0, 24'(entrada0), 24'd0);
        check("rst_tab0",   0, tab0,          24'd0);
        rst = 1'b0;

        run_sweep(0, 0, 0, 0, 1'b1);          // clean sweep, idle abort ignored
        stuck_and = 1'b1;
        run_sweep(0, 0, 0, 0, 1'b0);          // AND stuck at 0
        stuck_and = 1'b0;
        run_sweep(0, 0, 5, 0, 1'b0);          // start re-pulsed mid-sweep
        run_sweep(0, 7, 0, 0, 1'b0);          // abort in settle of vector 2
        run_sweep(0, 0, 0, 6, 1'b0);          // reset in sample of vector 1
        run_sweep(0, 0, 0, 0, 1'b0);
        run_sweep(1, 0, 0, 0, 1'b0);          // zero settle cycles
        run_sweep(0, 13, 0, 0, 1'b0);         // abort in the done cycle
        run_sweep(0, 3, 0, 0, 1'b0);          // abort in sample of vector 0

        for (int i = 0; i < 24; i++) begin
            use0 = int'($urandom_range(0, 1));
            t    = use0 ? 8 : 12;
            fault_vec = ($urandom_range(0, 1) == 0) ? 24'd0 : 24'($urandom & $urandom & $urandom);
            stuck_and = ($urandom_range(0, 5) == 0);
            mode = int'($urandom_range(0, 3));
            ac = 0; rsc = 0; rc = 0; ia = 1'b0;
            if (mode == 1)      ac  = int'($urandom_range(1, t + 1));
            else if (mode == 2) rsc = int'($urandom_range(1, t));
            else                ia  = 1'(($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1)
                rc = int'($urandom_range(1, (ac > 0) ? ac : (rsc > 0) ? rsc : t + 1));
            run_sweep(1'(use0), ac, rc, rsc, ia);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
